// File: rtl/vid_st_window_crop.sv
// vid_st_window_crop: forwards a rectangular window of each frame from a pixel stream, with optional 2:1 decimation (CROP_DECIM_EN)
module vid_st_window_crop #(
    parameter int DATA_W = 24,
    parameter int LINE_W = 640,
    parameter int CNT_W  = 12
) (
    input  logic              iCLK,
    input  logic              iRESETn,
    input  logic              iENABLE,
    input  logic [CNT_W-1:0]  iX0,
    input  logic [CNT_W-1:0]  iY0,
    input  logic [CNT_W-1:0]  iWIDTH,
    input  logic [CNT_W-1:0]  iHEIGHT,
`ifdef CROP_DECIM_EN
    input  logic              iDECIM,
`endif
    input  logic [DATA_W-1:0] iDATA,
    input  logic              iDV,
    input  logic              iSTART,
    output logic [DATA_W-1:0] oDATA,
    output logic              oDV,
    output logic              oSTART,
    output logic              oBUSY,
    output logic [15:0]       oFRAME_CNT
);
    typedef enum logic [1:0] {IDLE, ACTIVE, DONE} state_t;
    localparam logic [CNT_W-1:0] X_MAX   = CNT_W'(LINE_W - 1);
    localparam logic [CNT_W:0]   X_MAX_E = {1'b0, X_MAX};
    localparam logic [CNT_W:0]   ONE_E   = (CNT_W + 1)'(1);
    state_t           state, state_nx;
    logic [CNT_W-1:0] x, y, sx0, sy0, sw, sh;
    logic [CNT_W-1:0] cx, cy, ex0, ey0, ew, eh, nx, ny;
    logic [CNT_W:0]   x_end, y_end, x_last, y_last;
    logic             go, act, in_win, is_last, hit, keep, fwd;
`ifdef CROP_DECIM_EN
    logic             sdec, edec;
`endif

    // A start cycle uses the incoming config and position (0,0) for its own pixel
    always_comb begin
        cx      = iSTART ? '0 : x;
        cy      = iSTART ? '0 : y;
        ex0     = iSTART ? iX0 : sx0;
        ey0     = iSTART ? iY0 : sy0;
        ew      = iSTART ? iWIDTH : sw;
        eh      = iSTART ? iHEIGHT : sh;
        go      = iENABLE && (iWIDTH != '0) && (iHEIGHT != '0);
        act     = iSTART ? go : (state == ACTIVE);
        x_end   = {1'b0, ex0} + {1'b0, ew};
        y_end   = {1'b0, ey0} + {1'b0, eh};
        x_last  = ((x_end - ONE_E) > X_MAX_E) ? X_MAX_E : (x_end - ONE_E);
        y_last  = y_end - ONE_E;
        in_win  = (cx >= ex0) && ({1'b0, cx} < x_end) && (cy >= ey0) && ({1'b0, cy} < y_end);
        is_last = ({1'b0, cx} == x_last) && ({1'b0, cy} == y_last);
        hit     = act && iDV && in_win;
`ifdef CROP_DECIM_EN
        edec    = iSTART ? iDECIM : sdec;
        keep    = !edec || ((cx[0] == ex0[0]) && (cy[0] == ey0[0]));
`else
        keep    = 1'b1;
`endif
        fwd     = hit && keep;
        nx      = (cx == X_MAX) ? '0 : cx + CNT_W'(1);
        ny      = ((cx == X_MAX) && (cy != '1)) ? cy + CNT_W'(1) : cy;
        state_nx = (hit && is_last) ? DONE : iSTART ? (go ? ACTIVE : IDLE) : state;
    end

    // Window FSM register
    always_ff @(posedge iCLK) begin
        state <= !iRESETn ? IDLE : state_nx;
    end

    // Position counters and config shadowed at frame start
    always_ff @(posedge iCLK) begin
        if (!iRESETn) begin
            x   <= '0;
            y   <= '0;
            sx0 <= '0;
            sy0 <= '0;
            sw  <= '0;
            sh  <= '0;
`ifdef CROP_DECIM_EN
            sdec <= 1'b0;
`endif
        end else begin
            if (iDV) begin
                x <= nx;
                y <= ny;
            end else if (iSTART) begin
                x <= '0;
                y <= '0;
            end
            if (iSTART) begin
                sx0 <= iX0;
                sy0 <= iY0;
                sw  <= iWIDTH;
                sh  <= iHEIGHT;
`ifdef CROP_DECIM_EN
                sdec <= iDECIM;
`endif
            end
        end
    end

    // Registered outputs, one cycle behind the input pixel
    always_ff @(posedge iCLK) begin
        if (!iRESETn) begin
            oDATA      <= '0;
            oDV        <= 1'b0;
            oSTART     <= 1'b0;
            oFRAME_CNT <= '0;
        end else begin
            oDV    <= fwd;
            oSTART <= iSTART && go;
            if (fwd) oDATA <= iDATA;
            if (hit && is_last) oFRAME_CNT <= oFRAME_CNT + 16'd1;
        end
    end

    assign oBUSY = (state == ACTIVE);
endmodule
